weight_mem_loader: RTL and testbench

- Write-side companion to the synchronous weight ROM read port.
- Accepts a narrow byte stream from the host link (UART/SPI front end) over a valid/ready handshake.
- Assembles the bytes MSB-first into dataWidth-bit weight words and issues single-cycle write strobes into a weight RAM, one per word, at addresses 0 to numWeight-1.
- Signals completion so the inference controller can release the read side.

---
 rtl/weight_mem_loader.sv | 128 ++++++++++++
 tb/tb_weight_mem_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_mem_loader.sv
// Byte-stream loader for the weight RAM: assembles MSB-first beats into
// words and strobes them into addresses 0..numWeight-1, then pulses done.
module weight_mem_loader #(
    parameter int numWeight    = 16,
    parameter int addressWidth = 4,
    parameter int dataWidth    = 16,
    parameter int inWidth      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [inWidth-1:0]      in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    wen,
    output logic [addressWidth-1:0] wadd,
    output logic [dataWidth-1:0]    win,
    output logic                    busy,
    output logic                    done
);

    localparam int BPW = dataWidth / inWidth;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BPW - 1);
    localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [BCW-1:0]          beat;
    logic [addressWidth-1:0] addr;
    logic [dataWidth-1:0]    word_nx;
    logic                    hs;
    logic                    last;

    assign hs   = in_valid & in_ready;
    assign last = hs && (beat == LAST_BEAT);

    // Only the first BPW-1 beats need holding; the last one goes straight to win.
    generate
        if (BPW > 1) begin : g_shreg
            logic [dataWidth-inWidth-1:0] shreg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shreg <= '0;
                end else if (hs) begin
                    shreg <= word_nx[dataWidth-inWidth-1:0];
                end
            end

            assign word_nx = {shreg, in_data};
        end else begin : g_noshreg
            assign word_nx = in_data;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = LOAD;
            LOAD:  if (last) state_nx = WRITE;
            WRITE: state_nx = (addr == LAST_ADDR) ? DONE : LOAD;
            DONE:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        wen      = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: ;
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            WRITE: begin
                wen  = 1'b1;
                busy = 1'b1;
            end
            DONE: done = 1'b1;
        endcase
    end

    // wadd/win are loaded together with the last beat so they hold between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
            addr <= '0;
            wadd <= '0;
            win  <= '0;
        end else begin
            if (state == IDLE && start) begin
                beat <= '0;
                addr <= '0;
            end
            if (hs) begin
                if (last) begin
                    beat <= '0;
                    win  <= word_nx;
                    wadd <= addr;
                end else begin
                    beat <= beat + 1'b1;
                end
            end
            if (state == WRITE && addr != LAST_ADDR) begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_weight_mem_loader.sv
// Bench for weight_mem_loader: randomized beat streams against a
// word-assembly reference, plus a single-byte-word variant.
module tb_weight_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, in_valid, in_ready, wen, busy, done;
    logic [7:0]  in_data;
    logic [3:0]  wadd;
    logic [15:0] win;

    logic        start1, in_valid1, in_ready1, wen1, busy1, done1;
    logic [7:0]  in_data1;
    logic [3:0]  wadd1;
    logic [7:0]  win1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int          wcyc[$];
    logic [3:0]  wa[$];
    logic [15:0] wd[$];
    int          dcyc[$];

    always #5 clk = ~clk;

    weight_mem_loader #(
        .numWeight(4), .addressWidth(4), .dataWidth(16), .inWidth(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .wen(wen),
        .wadd(wadd), .win(win), .busy(busy), .done(done)
    );

    weight_mem_loader #(
        .numWeight(1), .addressWidth(4), .dataWidth(8), .inWidth(8)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_data(in_data1),
        .in_valid(in_valid1), .in_ready(in_ready1), .wen(wen1),
        .wadd(wadd1), .win(win1), .busy(busy1), .done(done1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (wen) begin
                wcyc.push_back(cyc);
                wa.push_back(wadd);
                wd.push_back(win);
            end
            if (done) dcyc.push_back(cyc);
        end
    end

    task automatic clr_mon();
        wcyc.delete();
        wa.delete();
        wd.delete();
        dcyc.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] b);
        bit acc;
        acc      = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = in_ready;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_accept: beat %h not accepted in 50 cycles", b);
        end
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        #1;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_done_timeout: done never seen", nm);
        end
    endtask

    // Reference: word i is {b[2i], b[2i+1]} written at address i; done follows last write.
    task automatic check_writes(input logic [7:0] b[8], input bit tight,
                                input string nm);
        logic [15:0] exp_d;
        n_tests++;
        if (wa.size() !== 4) begin
            n_fail++;
            $display("FAIL %s_count: got %0d writes, want 4", nm, wa.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < wa.size()) begin
                exp_d = {b[2*i], b[2*i+1]};
                n_tests++;
                if (wa[i] !== 4'(i) || wd[i] !== exp_d) begin
                    n_fail++;
                    $display("FAIL %s_word%0d: got (%0d,%h) want (%0d,%h)",
                             nm, i, wa[i], wd[i], i, exp_d);
                end
            end
        end
        n_tests++;
        if (dcyc.size() != 1 || wcyc.size() == 0 ||
            dcyc[0] != wcyc[wcyc.size()-1] + 1) begin
            n_fail++;
            $display("FAIL %s_done_timing: %0d done pulses, want 1 right after last wen",
                     nm, dcyc.size());
        end
        if (tight) begin
            for (int i = 1; i < wcyc.size(); i++) begin
                n_tests++;
                if (wcyc[i] - wcyc[i-1] != 3) begin
                    n_fail++;
                    $display("FAIL %s_spacing%0d: got %0d cycles want 3",
                             nm, i, wcyc[i] - wcyc[i-1]);
                end
            end
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || wen !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%b in_ready=%b done=%b wen=%b want 0000",
                     nm, busy, in_ready, done, wen);
        end
    endtask

    task automatic run_load(input logic [7:0] b[8], input int gapmax,
                            input bit xstart, input string nm);
        clr_mon();
        do_start();
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, gapmax)) @(negedge clk);
            if (xstart && i == 3) do_start();
            send_beat(b[i]);
        end
        wait_done(nm);
        check_writes(b, gapmax == 0 && !xstart, nm);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b0 || wen !== 1'b0 || busy !== 1'b0 ||
                done !== 1'b0 || wadd !== 4'd0 || win !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_idle%0d: rdy=%b wen=%b busy=%b done=%b wadd=%0d win=%h want all 0",
                         i, in_ready, wen, busy, done, wadd, win);
            end
        end
        n_tests++;
        if (in_ready1 !== 1'b0 || wen1 !== 1'b0 || busy1 !== 1'b0 ||
            done1 !== 1'b0 || win1 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_dut1: rdy=%b wen=%b busy=%b done=%b win=%h want all 0",
                     in_ready1, wen1, busy1, done1, win1);
        end
    endtask

    task automatic test_first_word();
        logic [7:0] b[8];
        b[0] = 8'h12;
        b[1] = 8'h34;
        for (int i = 2; i < 8; i++) b[i] = 8'($urandom);
        clr_mon();
        do_start();
        send_beat(b[0]);
        send_beat(b[1]);
        n_tests++;
        if (wen !== 1'b1 || wadd !== 4'd0 || win !== 16'h1234 ||
            in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_write: wen=%b wadd=%0d win=%h rdy=%b busy=%b want 1,0,1234,0,1",
                     wen, wadd, win, in_ready, busy);
        end
        @(negedge clk);
        n_tests++;
        if (wen !== 1'b0 || win !== 16'h1234 || wadd !== 4'd0) begin
            n_fail++;
            $display("FAIL first_pulse: wen=%b wadd=%0d win=%h want 0,0,1234",
                     wen, wadd, win);
        end
        for (int i = 2; i < 8; i++) send_beat(b[i]);
        wait_done("first");
        check_writes(b, 1'b0, "first");
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[8];
        for (int i = 0; i < 8; i++) b[i] = 8'(i);
        run_load(b, 0, 1'b0, "b2b");
    endtask

    task automatic test_gaps();
        logic [7:0] b[8];
        for (int i = 0; i < 8; i++) b[i] = 8'(i);
        for (int r = 0; r < 3; r++) run_load(b, 6, 1'b1, "gaps");
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        run_load(b, 3, 1'b0, "rand");
    endtask

    task automatic test_mid_reset();
        logic [7:0] b[8];
        logic [7:0] p[3];
        for (int i = 0; i < 3; i++) p[i] = 8'($urandom);
        clr_mon();
        do_start();
        for (int i = 0; i < 3; i++) send_beat(p[i]);
        n_tests++;
        if (wa.size() != 1 || wd[0] !== {p[0], p[1]}) begin
            n_fail++;
            $display("FAIL rst_pre: got %0d writes, want 1 of %h", wa.size(), {p[0], p[1]});
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (wen !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: wen=%b busy=%b rdy=%b done=%b want 0000",
                     wen, busy, in_ready, done);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (wa.size() != 1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_idle: writes=%0d busy=%b rdy=%b want 1,0,0",
                     wa.size(), busy, in_ready);
        end
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        run_load(b, 2, 1'b0, "reload");
    endtask

    task automatic test_single_byte();
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1    = 1'b0;
        in_data1  = 8'hA5;
        in_valid1 = 1'b1;
        n_tests++;
        if (in_ready1 !== 1'b1 || busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL v1_load: rdy=%b busy=%b want 1,1", in_ready1, busy1);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        n_tests++;
        if (wen1 !== 1'b1 || wadd1 !== 4'd0 || win1 !== 8'hA5 || in_ready1 !== 1'b0) begin
            n_fail++;
            $display("FAIL v1_write: wen=%b wadd=%0d win=%h rdy=%b want 1,0,a5,0",
                     wen1, wadd1, win1, in_ready1);
        end
        @(negedge clk);
        n_tests++;
        if (wen1 !== 1'b0 || done1 !== 1'b1 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL v1_done: wen=%b done=%b busy=%b want 0,1,0", wen1, done1, busy1);
        end
        @(negedge clk);
        n_tests++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || win1 !== 8'hA5) begin
            n_fail++;
            $display("FAIL v1_idle: done=%b busy=%b win=%h want 0,0,a5", done1, busy1, win1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        start1    = 1'b0;
        in_valid1 = 1'b0;
        in_data1  = 8'h00;
        @(negedge clk);
        test_reset();
        test_first_word();
        test_back_to_back();
        test_gaps();
        test_mid_reset();
        test_single_byte();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
